// File: rtl/br_writer_pkg.sv
// br_writer_pkg: shared constants, FSM encoding and the chunk mask helper
// for the bit-reservoir writer.
package br_writer_pkg;

  localparam int BR_ADDR_W = 8;
  localparam int BR_DEPTH  = 256;
  localparam int WORD_W    = 16;
  localparam int NBITS_W   = 5;

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_FLUSH  = 1'b1
  } br_state_e;

  // Low n bits set; lengths above WORD_W saturate to a full word.
  function automatic logic [WORD_W-1:0] chunk_mask(input logic [NBITS_W-1:0] n);
    if (n >= NBITS_W'(WORD_W)) return '1;
    return (WORD_W'(1) << n) - WORD_W'(1);
  endfunction

endpackage

// File: rtl/br_writer_if.sv
// br_writer_if: variable-length chunk input stream of the reservoir writer.
//   in_valid  chunk present
//   in_ready  chunk taken when in_valid && in_ready
//   in_data   chunk bits, right-aligned
//   in_nbits  chunk length 0..16 (0 = accepted, nothing appended)
interface br_writer_if;
  import br_writer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic [NBITS_W-1:0]  in_nbits;

  modport master (output in_valid, output in_data, output in_nbits, input in_ready);
  modport slave  (input in_valid, input in_data, input in_nbits, output in_ready);

endinterface

// File: rtl/br_bitpacker.sv
// br_bitpacker: MSB-first shift-append accumulator for the reservoir writer.
//   clk, resetn, clear  clock, sync active-low reset, sync clear
//   push, nbits, data   append nbits of data (right-aligned) this cycle
//   flush_take          discard the partial word (it has been written out)
//   fill                number of pending bits held (0..15)
//   word_vld, word      a full 16-bit word completes with this push
//   flush_word          pending bits moved to the MSBs, zero-padded
module br_bitpacker
  import br_writer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                push,
  input  logic [NBITS_W-1:0]  nbits,
  input  logic [WORD_W-1:0]   data,
  input  logic                flush_take,
  output logic [NBITS_W-1:0]  fill,
  output logic                word_vld,
  output logic [WORD_W-1:0]   word,
  output logic [WORD_W-1:0]   flush_word
);

  // Only the low 'fill' bits of acc are meaningful; fill never exceeds 15
  // between cycles, so 16 bits of storage suffice.
  logic [WORD_W-1:0]    acc;
  logic [NBITS_W-1:0]   n_eff;
  logic [2*WORD_W-1:0]  acc_cat;
  logic [NBITS_W-1:0]   fill_sum;
  logic [NBITS_W-1:0]   sh;

  always_comb begin
    n_eff      = (nbits > NBITS_W'(WORD_W)) ? NBITS_W'(WORD_W) : nbits;
    acc_cat    = ({{WORD_W{1'b0}}, acc} << n_eff) | {{WORD_W{1'b0}}, data & chunk_mask(n_eff)};
    // 15 + 16 = 31 still fits in five bits.
    fill_sum   = fill + n_eff;
    word_vld   = push && (fill_sum >= NBITS_W'(WORD_W));
    sh         = fill_sum - NBITS_W'(WORD_W);
    word       = WORD_W'(acc_cat >> sh);
    // fill == 0 shifts everything out, giving 0, which is never written.
    flush_word = WORD_W'({{WORD_W{1'b0}}, acc} << (NBITS_W'(WORD_W) - fill));
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      acc  <= '0;
      fill <= '0;
    end else if (flush_take) begin
      acc  <= '0;
      fill <= '0;
    end else if (push) begin
      acc  <= acc_cat[WORD_W-1:0];
      fill <= word_vld ? sh : fill_sum;
    end
  end

endmodule

// File: rtl/br_writer.sv
// br_writer: write side of the 256x16 bit reservoir. Packs chunks into
// 16-bit words, writes them to the reservoir RAM and tracks occupancy.
//   clk, resetn, clear        clock, sync active-low reset, sync clear
//   in_if                     chunk stream (valid/ready/data/nbits)
//   flush, flush_done         pad-and-write partial word; completion pulse
//   br_we, br_wr_address,
//   br_datain                 registered RAM write port
//   br_update                 reader consumed one word
//   br_count, br_count_is_zero,
//   br_full                   occupancy 0..DEPTH and its flags
//   br_rd_start               address of the oldest held word
module br_writer
  import br_writer_pkg::*;
#(
  parameter int ADDR_W = BR_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  br_writer_if.slave        in_if,
  input  logic              flush,
  output logic              flush_done,
  output logic              br_we,
  output logic [ADDR_W-1:0] br_wr_address,
  output logic [WORD_W-1:0] br_datain,
  input  logic              br_update,
  output logic [ADDR_W:0]   br_count,
  output logic              br_count_is_zero,
  output logic              br_full,
  output logic [ADDR_W-1:0] br_rd_start
);

  localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

  br_state_e            state, state_nxt;
  logic [ADDR_W-1:0]    wptr;
  logic                 we_p1, fd_p1;
  logic [WORD_W-1:0]    data_p1;

  logic                 in_rdy, push, flush_take;
  logic                 wr_nxt, fd_nxt;
  logic [WORD_W-1:0]    wdata_nxt;
  logic                 room, dec;
  logic [ADDR_W+1:0]    cnt_pend;

  logic [NBITS_W-1:0]   fill;
  logic                 word_vld;
  logic [WORD_W-1:0]    word, flush_word;

  br_bitpacker u_pack (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .push       (push),
    .nbits      (in_if.in_nbits),
    .data       (in_if.in_data),
    .flush_take (flush_take),
    .fill       (fill),
    .word_vld   (word_vld),
    .word       (word),
    .flush_word (flush_word)
  );

  // The write is registered, so the word sitting on br_we this cycle is
  // not yet in br_count; counting it here keeps a write from landing at DEPTH.
  assign cnt_pend = {1'b0, br_count} + (ADDR_W+2)'(we_p1);
  assign room     = cnt_pend < DEPTH_X;
  assign dec      = br_update && (br_count != '0);

  always_ff @(posedge clk) begin
    if (!resetn || clear) state <= ST_ACCEPT;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_rdy     = 1'b0;
    push       = 1'b0;
    flush_take = 1'b0;
    wr_nxt     = 1'b0;
    wdata_nxt  = word;
    fd_nxt     = 1'b0;
    case (state)
      ST_ACCEPT: begin
        in_rdy = room && !flush;
        push   = in_if.in_valid && in_rdy;
        wr_nxt = word_vld;
        if (flush) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fill == '0) begin
          fd_nxt    = 1'b1;
          state_nxt = ST_ACCEPT;
        end else if (room) begin
          wr_nxt     = 1'b1;
          wdata_nxt  = flush_word;
          flush_take = 1'b1;
          fd_nxt     = 1'b1;
          state_nxt  = ST_ACCEPT;
        end
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  // p0 -> p1: decided write becomes the RAM strobe; pointer and count
  // advance on the edge that retires it.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wptr     <= '0;
      br_count <= '0;
      we_p1    <= 1'b0;
      fd_p1    <= 1'b0;
      data_p1  <= '0;
    end else begin
      we_p1    <= wr_nxt;
      fd_p1    <= fd_nxt;
      if (wr_nxt) data_p1 <= wdata_nxt;
      if (we_p1)  wptr <= wptr + ADDR_W'(1);
      br_count <= br_count + (ADDR_W+1)'(we_p1) - (ADDR_W+1)'(dec);
    end
  end

  assign in_if.in_ready   = in_rdy;
  assign br_we            = we_p1;
  assign br_wr_address    = wptr;
  assign br_datain        = data_p1;
  assign flush_done       = fd_p1;
  assign br_count_is_zero = (br_count == '0);
  assign br_full          = (br_count == (ADDR_W+1)'(DEPTH));
  assign br_rd_start      = wptr - br_count[ADDR_W-1:0];

endmodule

// File: tb/tb_br_writer.sv
// tb_br_writer: directed stimulus with a write scoreboard for br_writer.
module tb_br_writer;
  import br_writer_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic        flush = 1'b0;
  logic        br_update = 1'b0;
  logic        flush_done, br_we, br_count_is_zero, br_full;
  logic [7:0]  br_wr_address, br_rd_start;
  logic [15:0] br_datain;
  logic [8:0]  br_count;

  br_writer_if bif();

  br_writer dut (
    .clk              (clk),
    .resetn           (resetn),
    .clear            (clear),
    .in_if            (bif),
    .flush            (flush),
    .flush_done       (flush_done),
    .br_we            (br_we),
    .br_wr_address    (br_wr_address),
    .br_datain        (br_datain),
    .br_update        (br_update),
    .br_count         (br_count),
    .br_count_is_zero (br_count_is_zero),
    .br_full          (br_full),
    .br_rd_start      (br_rd_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [7:0] a, input logic [15:0] d, input logic fd);
    exp_t e;
    e.we = 1'b1; e.addr = a; e.data = d; e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic exp_fd_only();
    exp_t e;
    e.we = 1'b0; e.addr = '0; e.data = '0; e.fd = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe or flush_done pulse consumes one expectation.
  always @(negedge clk) begin
    if (resetn && (br_we || flush_done)) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_event: we=%0d addr=0x%0h data=0x%0h flush_done=%0d, expected none",
                 br_we, br_wr_address, br_datain, flush_done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_we", 32'(br_we), 32'(mon_e.we));
        if (mon_e.we) begin
          chk("wr_addr", 32'(br_wr_address), 32'(mon_e.addr));
          chk("wr_data", 32'(br_datain), 32'(mon_e.data));
        end
        chk("flush_done", 32'(flush_done), 32'(mon_e.fd));
      end
    end
  end

  task automatic send(input logic [4:0] nb, input logic [15:0] d);
    int waited = 0;
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_nbits = nb;
    bif.in_data  = d;
    while (!bif.in_ready && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (!bif.in_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", waited);
    end else begin
      @(posedge clk);
    end
    #1 bif.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic pulse_update();
    @(negedge clk);
    br_update = 1'b1;
    @(posedge clk);
    #1 br_update = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    bif.in_nbits = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_count", 32'(br_count), 32'd0);
    chk("rst_zero", 32'(br_count_is_zero), 32'd1);
    chk("rst_full", 32'(br_full), 32'd0);
    chk("rst_rd_start", 32'(br_rd_start), 32'd0);
    chk("rst_we", 32'(br_we), 32'd0);
    chk("rst_addr", 32'(br_wr_address), 32'd0);
    chk("rst_datain", 32'(br_datain), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);

    // 4+4+8 bits make exactly one word; flush then has nothing to write
    expw(8'd0, 16'hA53C, 1'b0);
    send(5'd4, 16'h000A);
    send(5'd4, 16'h0005);
    send(5'd8, 16'h003C);
    exp_fd_only();
    do_flush();
    settle();
    chk("t1_count", 32'(br_count), 32'd1);
    chk("t1_rd_start", 32'(br_rd_start), 32'd0);

    // 12+12 bits: one word, 8 left over, flushed as 0xEF00
    pulse_clear();
    expw(8'd0, 16'hABCD, 1'b0);
    send(5'd12, 16'h0ABC);
    send(5'd12, 16'h0DEF);
    expw(8'd1, 16'hEF00, 1'b1);
    do_flush();
    settle();
    chk("t2_count", 32'(br_count), 32'd2);
    chk("t2_rd_start", 32'(br_rd_start), 32'd0);

    // Fill the reservoir completely
    pulse_clear();
    for (int i = 0; i < 256; i++) begin
      expw(8'(i), 16'(i), 1'b0);
      send(5'd16, 16'(i));
    end
    settle();
    chk("t3_full", 32'(br_full), 32'd1);
    chk("t3_count", 32'(br_count), 32'd256);
    chk("t3_in_ready", 32'(bif.in_ready), 32'd0);
    chk("t3_rd_start_full", 32'(br_rd_start), 32'd0);
    // Next chunk stalls while full
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_nbits = 5'd16;
    bif.in_data  = 16'h1234;
    repeat (3) @(negedge clk);
    chk("t3_stall_ready", 32'(bif.in_ready), 32'd0);
    expw(8'd0, 16'h1234, 1'b0);
    br_update = 1'b1;
    @(posedge clk);
    #1 br_update = 1'b0;
    @(negedge clk);
    chk("t3_count_after_update", 32'(br_count), 32'd255);
    waited = 0;
    while (!bif.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t3_ready_after_update", 32'(bif.in_ready), 32'd1);
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
    settle();
    chk("t3_count_wrap", 32'(br_count), 32'd256);
    chk("t3_rd_start_wrap", 32'(br_rd_start), 32'd1);

    // Write and update in the same cycle at count 10
    pulse_clear();
    for (int k = 0; k < 10; k++) begin
      expw(8'(k), 16'h0B00 + 16'(k), 1'b0);
      send(5'd16, 16'h0B00 + 16'(k));
    end
    settle();
    chk("t4_count10", 32'(br_count), 32'd10);
    expw(8'd10, 16'h0BB0, 1'b0);
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_nbits = 5'd16;
    bif.in_data  = 16'h0BB0;
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
    br_update = 1'b1;
    chk("t4_we_overlap", 32'(br_we), 32'd1);
    @(posedge clk);
    #1 br_update = 1'b0;
    chk("t4_count_same", 32'(br_count), 32'd10);
    for (int k = 0; k < 10; k++) pulse_update();
    @(negedge clk);
    chk("t4_count_drained", 32'(br_count), 32'd0);
    pulse_update();
    @(negedge clk);
    chk("t4_count_stays0", 32'(br_count), 32'd0);
    chk("t4_zero_flag", 32'(br_count_is_zero), 32'd1);
    chk("t4_rd_start", 32'(br_rd_start), 32'd11);

    // clear mid-stream drops the word completing on the same edge
    pulse_clear();
    for (int k = 0; k < 5; k++) begin
      expw(8'(k), 16'h0C00 + 16'(k), 1'b0);
      send(5'd16, 16'h0C00 + 16'(k));
    end
    send(5'd8, 16'h0077);
    settle();
    chk("t5_count5", 32'(br_count), 32'd5);
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_nbits = 5'd8;
    bif.in_data  = 16'h0088;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    bif.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_count", 32'(br_count), 32'd0);
    chk("t5_clr_we", 32'(br_we), 32'd0);
    chk("t5_clr_wptr", 32'(br_wr_address), 32'd0);
    chk("t5_clr_rd_start", 32'(br_rd_start), 32'd0);
    expw(8'd0, 16'h1357, 1'b0);
    send(5'd16, 16'h1357);
    settle();
    chk("t5_clr_after", 32'(br_count), 32'd1);

    // Same with resetn
    for (int k = 1; k < 6; k++) begin
      expw(8'(k), 16'h0D00 + 16'(k), 1'b0);
      send(5'd16, 16'h0D00 + 16'(k));
    end
    send(5'd8, 16'h0077);
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_nbits = 5'd8;
    bif.in_data  = 16'h0088;
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    bif.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_rst_count", 32'(br_count), 32'd0);
    chk("t5_rst_we", 32'(br_we), 32'd0);
    chk("t5_rst_wptr", 32'(br_wr_address), 32'd0);
    expw(8'd0, 16'h2468, 1'b0);
    send(5'd16, 16'h2468);
    settle();
    chk("t5_rst_after", 32'(br_count), 32'd1);

    // nbits=0 is a no-op; bits above nbits are ignored
    pulse_clear();
    send(5'd0, 16'hFFFF);
    send(5'd3, 16'hFFF9);
    send(5'd0, 16'h1234);
    settle();
    chk("t6_no_write", 32'(br_count), 32'd0);
    expw(8'd0, 16'h2ABC, 1'b0);
    send(5'd13, 16'h0ABC);
    settle();
    chk("t6_count", 32'(br_count), 32'd1);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
